// File: rtl/kb_arb_pkg.sv
// Shared types, prefix constants and width helpers for the scancode arbiter.
package kb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } kb_state_e;

  localparam logic [7:0] KB_PFX_E0 = 8'hE0;
  localparam logic [7:0] KB_PFX_E1 = 8'hE1;
  localparam logic [7:0] KB_PFX_F0 = 8'hF0;

  // True for bytes that open a multi-byte PS/2 sequence.
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == KB_PFX_E0) || (b == KB_PFX_E1) || (b == KB_PFX_F0);
  endfunction

  // Bits needed for a counter that holds values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/kb_scancode_arb_picker.sv
// Combinational winner picker: round-robin from a start pointer, or fixed
// lowest-index priority when KB_ARB_FIXPRIO_EN is defined.
module kb_rr_picker
  import kb_arb_pkg::*;
#(
  parameter int unsigned NSRC = 3,
  parameter int unsigned IDXW = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req_i,
  input  logic [IDXW-1:0] start_i,
  input  logic [NSRC-1:0] mask_i,
  output logic [IDXW-1:0] win_idx_c_o,
  output logic            found_c_o
);

  logic [NSRC-1:0] elig;
  assign elig = req_i & mask_i;

`ifdef KB_ARB_FIXPRIO_EN
  logic unused_start;
  assign unused_start = ^start_i;

  // Lowest-indexed eligible source wins.
  always_comb begin
    win_idx_c_o = '0;
    found_c_o   = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!found_c_o && elig[i]) begin
        win_idx_c_o = IDXW'(i);
        found_c_o   = 1'b1;
      end
    end
  end
`else
  // First eligible source at or after start_i, wrapping at NSRC.
  always_comb begin
    int unsigned idx;
    win_idx_c_o = '0;
    found_c_o   = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      idx = (32'(start_i) + k) % NSRC;
      if (!found_c_o && elig[IDXW'(idx)]) begin
        win_idx_c_o = IDXW'(idx);
        found_c_o   = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/kb_scancode_arb.sv
// Scancode arbiter: merges producer bytes into one toggle-strobed stream,
// keeps PS/2 prefix sequences atomic, spaces updates and sequences flushes.
// Build option: KB_ARB_FIXPRIO_EN selects fixed lowest-index priority.
module kb_scancode_arb
  import kb_arb_pkg::*;
#(
  parameter int unsigned NSRC         = 3,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned LOCK_TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NSRC*8-1:0]        src_scancode,
  input  logic [NSRC-1:0]          src_valid,
  output logic [NSRC-1:0]          src_ready,
  input  logic                     flush_req,
  output logic [7:0]               kb_scancode,
  output logic                     kb_scancode_upd,
  output logic                     keybuf_reset,
  output logic [$clog2(NSRC)-1:0]  grant_idx,
  output logic                     busy
);

  localparam int unsigned IDXW = $clog2(NSRC);
  localparam int unsigned GAPW = cnt_w(GAP_CYCLES);
  localparam int unsigned TOW  = cnt_w(LOCK_TIMEOUT);

  kb_state_e       state_q, state_d;
  logic [7:0]      kb_q, kb_d;
  logic            upd_q, upd_d;
  logic            kbr_q, kbr_d;
  logic [IDXW-1:0] grant_q, grant_d;
  logic [IDXW-1:0] rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [IDXW-1:0] lsrc_q, lsrc_d;
  logic [GAPW-1:0] gap_q, gap_d;
  logic [TOW-1:0]  to_q, to_d;
  logic            busy_q, busy_d;

  logic [NSRC-1:0] lock_mask;
  logic [IDXW-1:0] win_idx;
  logic            found;
  logic            accept;
  logic [7:0]      win_byte;

  assign lock_mask = lock_q ? (NSRC'(1) << lsrc_q) : {NSRC{1'b1}};

  kb_rr_picker #(.NSRC(NSRC), .IDXW(IDXW)) u_picker (
    .req_i       (src_valid),
    .start_i     (rr_q),
    .mask_i      (lock_mask),
    .win_idx_c_o (win_idx),
    .found_c_o   (found)
  );

  // Accept only when idle, out of reset and no flush is pending this cycle.
  assign accept    = reset_n && (state_q == IDLE) && found && !flush_req;
  assign src_ready = accept ? (NSRC'(1) << win_idx) : '0;

  // Byte presented by the current winner.
  always_comb begin
    win_byte = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (win_idx == IDXW'(i)) win_byte = src_scancode[i*8 +: 8];
    end
  end

  // Next-state: flush first, then acceptance, lock timeout and gap countdown.
  always_comb begin
    state_d = state_q;
    kb_d    = kb_q;
    upd_d   = upd_q;
    kbr_d   = 1'b0;
    grant_d = grant_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    lsrc_d  = lsrc_q;
    gap_d   = gap_q;
    to_d    = to_q;

    if (flush_req) begin
      kbr_d   = 1'b1;
      lock_d  = 1'b0;
      to_d    = '0;
      gap_d   = GAPW'(GAP_CYCLES - 1);
      state_d = GAP;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            kb_d    = win_byte;
            upd_d   = ~upd_q;
            grant_d = win_idx;
            state_d = GAP;
            gap_d   = GAPW'(GAP_CYCLES - 1);
            to_d    = '0;
`ifdef KB_ARB_FIXPRIO_EN
            rr_d    = '0;
`else
            rr_d    = (32'(win_idx) == NSRC - 1) ? '0 : win_idx + IDXW'(1);
`endif
            if (is_prefix(win_byte)) begin
              lock_d = 1'b1;
              lsrc_d = win_idx;
            end else if (lock_q && (win_idx == lsrc_q)) begin
              lock_d = 1'b0;
            end
          end else if (lock_q && !src_valid[lsrc_q]) begin
            if (to_q == TOW'(LOCK_TIMEOUT - 1)) begin
              lock_d = 1'b0;
              to_d   = '0;
            end else begin
              to_d = to_q + TOW'(1);
            end
          end
        end
        GAP: begin
          if (gap_q == '0) state_d = IDLE;
          else             gap_d   = gap_q - GAPW'(1);
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE) || lock_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      kb_q    <= '0;
      upd_q   <= 1'b0;
      kbr_q   <= 1'b0;
      grant_q <= '0;
      rr_q    <= '0;
      lock_q  <= 1'b0;
      lsrc_q  <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kb_q    <= kb_d;
      upd_q   <= upd_d;
      kbr_q   <= kbr_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      lsrc_q  <= lsrc_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end

  assign kb_scancode     = kb_q;
  assign kb_scancode_upd = upd_q;
  assign keybuf_reset    = kbr_q;
  assign grant_idx       = grant_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_kb_scancode_arb.sv
// Directed bench for kb_scancode_arb (NSRC=3, GAP_CYCLES=4, LOCK_TIMEOUT=1023).
module tb_kb_scancode_arb;

  logic        clk;
  logic        reset_n;
  logic [23:0] src_scancode;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic        flush_req;
  logic [7:0]  kb_scancode;
  logic        kb_scancode_upd;
  logic        keybuf_reset;
  logic [1:0]  grant_idx;
  logic        busy;

  kb_scancode_arb #(.NSRC(3), .GAP_CYCLES(4), .LOCK_TIMEOUT(1023)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .src_scancode    (src_scancode),
    .src_valid       (src_valid),
    .src_ready       (src_ready),
    .flush_req       (flush_req),
    .kb_scancode     (kb_scancode),
    .kb_scancode_upd (kb_scancode_upd),
    .keybuf_reset    (keybuf_reset),
    .grant_idx       (grant_idx),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Per-source byte queues driven onto the inputs.
  logic [7:0] q [3][4];
  int         qlen [3];
  int         qptr [3];

  // Logs gathered by run_sources, indexed by cycle relative to reset release.
  int         acc_src [16];
  int         acc_cyc [16];
  int         acc_n;
  logic [7:0] em_byte [16];
  logic       em_upd  [16];
  int         em_cyc  [16];
  int         em_n;
  logic       busy_log [2048];
  logic       kbr_log  [2048];
  int         kbr_n;
  int         ready_err;
  logic       upd_prev;

  task automatic clear_queues();
    for (int i = 0; i < 3; i++) begin
      qlen[i] = 0;
      qptr[i] = 0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (qptr[i] < qlen[i]) begin
        src_valid[i]          = 1'b1;
        src_scancode[i*8 +: 8] = q[i][qptr[i]];
      end else begin
        src_valid[i]          = 1'b0;
        src_scancode[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  // Reset, clear logs, present queue heads and release reset away from the edge.
  task automatic start_test();
    reset_n   = 1'b0;
    flush_req = 1'b0;
    src_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      acc_src[i] = -1;
      acc_cyc[i] = -1;
      em_byte[i] = 'x;
      em_upd[i]  = 'x;
      em_cyc[i]  = -1;
    end
    acc_n = 0; em_n = 0; kbr_n = 0; ready_err = 0;
    for (int i = 0; i < 3; i++) qptr[i] = 0;
    drive();
    reset_n  = 1'b1;
    upd_prev = kb_scancode_upd;
  endtask

  // Run ncyc cycles; flush_req is pulsed in relative cycles f1 and f2.
  task automatic run_sources(input int ncyc, input int f1, input int f2);
    logic [2:0] rdy;
    flush_req = (f1 == 0) || (f2 == 0);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rdy         = src_ready;
      busy_log[c] = busy;
      kbr_log[c]  = keybuf_reset;
      if (keybuf_reset) kbr_n++;
      if ($countones(rdy) > 1 || (rdy & ~src_valid) != 3'b000) ready_err++;
      if (kb_scancode_upd !== upd_prev && em_n < 16) begin
        em_byte[em_n] = kb_scancode;
        em_upd[em_n]  = kb_scancode_upd;
        em_cyc[em_n]  = c;
        em_n++;
        upd_prev = kb_scancode_upd;
      end
      for (int i = 0; i < 3; i++) begin
        if (rdy[i] && src_valid[i] && acc_n < 16) begin
          acc_src[acc_n] = i;
          acc_cyc[acc_n] = c;
          acc_n++;
          qptr[i]++;
        end
      end
      @(posedge clk);
      #1;
      drive();
      flush_req = (c + 1 == f1) || (c + 1 == f2);
    end
    flush_req = 1'b0;
  endtask

  task automatic test_reset();
    clear_queues();
    q[0][0] = 8'hAA; qlen[0] = 1;
    drive();
    flush_req = 1'b0;
    #2 reset_n = 1'b0;
    #2;
    chk_cnt++; if (kb_scancode !== 8'h00) $display("FAIL reset_kb got %h want 00", kb_scancode); else pass_cnt++;
    chk_cnt++; if (kb_scancode_upd !== 1'b0) $display("FAIL reset_upd got %b want 0", kb_scancode_upd); else pass_cnt++;
    chk_cnt++; if (keybuf_reset !== 1'b0) $display("FAIL reset_kbr got %b want 0", keybuf_reset); else pass_cnt++;
    chk_cnt++; if (grant_idx !== 2'd0) $display("FAIL reset_grant got %0d want 0", grant_idx); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (src_ready !== 3'b000) $display("FAIL reset_ready got %b want 000", src_ready); else pass_cnt++;
  endtask

  task automatic test_single();
    clear_queues();
    q[1][0] = 8'h1C; q[1][1] = 8'h2A; qlen[1] = 2;
    start_test();
    run_sources(12, -1, -1);
    chk_cnt++; if (acc_n !== 2) $display("FAIL single_acc_n got %0d want 2", acc_n); else pass_cnt++;
    chk_cnt++; if (acc_src[0] !== 1 || acc_cyc[0] !== 0) $display("FAIL single_first_acc got src%0d@%0d want src1@0", acc_src[0], acc_cyc[0]); else pass_cnt++;
    chk_cnt++; if (em_byte[0] !== 8'h1C || em_cyc[0] !== 1 || em_upd[0] !== 1'b1) $display("FAIL single_emit got %h@%0d upd %b want 1c@1 upd 1", em_byte[0], em_cyc[0], em_upd[0]); else pass_cnt++;
    chk_cnt++; if (acc_cyc[1] !== 5) $display("FAIL single_spacing got %0d want 5", acc_cyc[1]); else pass_cnt++;
    chk_cnt++; if (grant_idx !== 2'd1 || kb_scancode !== 8'h2A) $display("FAIL single_final got grant %0d kb %h want 1 2a", grant_idx, kb_scancode); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    clear_queues();
    for (int j = 0; j < 4; j++) begin
      q[0][j] = 8'h10; q[1][j] = 8'h20; q[2][j] = 8'h30;
    end
    qlen[0] = 4; qlen[1] = 4; qlen[2] = 4;
    start_test();
    run_sources(18, -1, -1);
    chk_cnt++; if (em_byte[0] !== 8'h10 || em_byte[1] !== 8'h20 || em_byte[2] !== 8'h30 || em_byte[3] !== 8'h10)
      $display("FAIL rr_order got %h %h %h %h want 10 20 30 10", em_byte[0], em_byte[1], em_byte[2], em_byte[3]); else pass_cnt++;
    chk_cnt++; if (acc_cyc[1] !== 5 || acc_cyc[2] !== 10 || acc_cyc[3] !== 15)
      $display("FAIL rr_spacing got %0d %0d %0d want 5 10 15", acc_cyc[1], acc_cyc[2], acc_cyc[3]); else pass_cnt++;
    chk_cnt++; if (ready_err !== 0) $display("FAIL rr_ready_onehot got %0d bad cycles want 0", ready_err); else pass_cnt++;
  endtask

  task automatic test_atomic();
    clear_queues();
    q[0][0] = 8'hE0; q[0][1] = 8'hF0; q[0][2] = 8'h75; qlen[0] = 3;
    q[1][0] = 8'h1C; qlen[1] = 1;
    start_test();
    run_sources(18, -1, -1);
    chk_cnt++; if (em_byte[0] !== 8'hE0 || em_byte[1] !== 8'hF0 || em_byte[2] !== 8'h75 || em_byte[3] !== 8'h1C)
      $display("FAIL atomic_order got %h %h %h %h want e0 f0 75 1c", em_byte[0], em_byte[1], em_byte[2], em_byte[3]); else pass_cnt++;
    chk_cnt++; if (busy_log[5] !== 1'b1) $display("FAIL atomic_busy_locked got %b want 1", busy_log[5]); else pass_cnt++;
  endtask

  task automatic test_lock_timeout();
    clear_queues();
    q[0][0] = 8'hE0; qlen[0] = 1;
    q[1][0] = 8'h29; qlen[1] = 1;
    start_test();
    run_sources(1032, -1, -1);
    chk_cnt++; if (acc_src[1] !== 1 || acc_cyc[1] !== 1028) $display("FAIL timeout_acc got src%0d@%0d want src1@1028", acc_src[1], acc_cyc[1]); else pass_cnt++;
    chk_cnt++; if (em_byte[1] !== 8'h29 || em_cyc[1] !== 1029) $display("FAIL timeout_emit got %h@%0d want 29@1029", em_byte[1], em_cyc[1]); else pass_cnt++;
    chk_cnt++; if (busy_log[1027] !== 1'b1 || busy_log[1028] !== 1'b0) $display("FAIL timeout_busy got %b%b want 10", busy_log[1027], busy_log[1028]); else pass_cnt++;
  endtask

  task automatic test_flush();
    clear_queues();
    q[0][0] = 8'hE0; qlen[0] = 1;
    q[2][0] = 8'h33; qlen[2] = 1;
    start_test();
    run_sources(12, 2, -1);
    chk_cnt++; if (kbr_log[3] !== 1'b1 || kbr_n !== 1) $display("FAIL flush_pulse got kbr[3]=%b count %0d want 1 1", kbr_log[3], kbr_n); else pass_cnt++;
    chk_cnt++; if (acc_src[1] !== 2 || acc_cyc[1] !== 7) $display("FAIL flush_next_acc got src%0d@%0d want src2@7", acc_src[1], acc_cyc[1]); else pass_cnt++;
    chk_cnt++; if (em_n !== 2 || em_cyc[1] !== 8) $display("FAIL flush_no_toggle got %0d emits, 2nd @%0d want 2 @8", em_n, em_cyc[1]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    clear_queues();
    q[2][0] = 8'h33; qlen[2] = 1;
    start_test();
    run_sources(12, 0, 1);
    chk_cnt++; if (kbr_log[1] !== 1'b1 || kbr_log[2] !== 1'b1 || kbr_n !== 2)
      $display("FAIL b2b_pulses got %b%b count %0d want 11 2", kbr_log[1], kbr_log[2], kbr_n); else pass_cnt++;
    chk_cnt++; if (acc_cyc[0] !== 6 || acc_src[0] !== 2) $display("FAIL b2b_acc got src%0d@%0d want src2@6", acc_src[0], acc_cyc[0]); else pass_cnt++;
    chk_cnt++; if (em_n !== 1 || em_byte[0] !== 8'h33) $display("FAIL b2b_emit got %0d emits byte %h want 1 33", em_n, em_byte[0]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_gap();
    clear_queues();
    q[1][0] = 8'hE0; qlen[1] = 1;
    start_test();
    run_sources(3, -1, -1);
    clear_queues();
    q[0][0] = 8'h05; qlen[0] = 1;
    q[2][0] = 8'h33; qlen[2] = 1;
    drive();
    reset_n = 1'b0;
    #2;
    chk_cnt++; if (kb_scancode !== 8'h00 || kb_scancode_upd !== 1'b0) $display("FAIL midrst_kb got %h upd %b want 00 0", kb_scancode, kb_scancode_upd); else pass_cnt++;
    chk_cnt++; if (grant_idx !== 2'd0 || busy !== 1'b0) $display("FAIL midrst_grant_busy got %0d %b want 0 0", grant_idx, busy); else pass_cnt++;
    chk_cnt++; if (src_ready !== 3'b000) $display("FAIL midrst_ready got %b want 000", src_ready); else pass_cnt++;
    start_test();
    run_sources(8, -1, -1);
    chk_cnt++; if (acc_src[0] !== 0 || acc_cyc[0] !== 0) $display("FAIL midrst_first got src%0d@%0d want src0@0", acc_src[0], acc_cyc[0]); else pass_cnt++;
    chk_cnt++; if (em_byte[0] !== 8'h05) $display("FAIL midrst_byte got %h want 05", em_byte[0]); else pass_cnt++;
  endtask

  initial begin
    reset_n      = 1'b1;
    flush_req    = 1'b0;
    src_valid    = '0;
    src_scancode = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_atomic();
    test_lock_timeout();
    test_flush();
    test_back_to_back();
    test_reset_mid_gap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
